// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM encodings shared by the ALU and its issue controller
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_MUL = 3'd4,
    OP_DIV = 3'd5,
    OP_LDA = 3'd6,
    OP_RSV = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  function automatic int unsigned settle_eff(int unsigned n);
    return n == 0 ? 1 : n;
  endfunction
endpackage

// File: rtl/alu_settle_timer.sv
// alu_settle_timer: loadable down-counter whose done flag marks the last settle cycle
//   clk, rst_n        clock, async active-low reset
//   i_load/i_load_val load the dwell length (>=1)
//   i_dec             count one dwell cycle
//   o_done            high while exactly one dwell cycle remains
module alu_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = r_cnt == W'(1);
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one accumulator command at a time to a combinational ALU
//   cmd_*  command handshake (op, B operand / load value)
//   alu_*  operands and select for the external ALU, zero outside EXEC
//   rsp_*  response handshake with new accumulator value, zero flag, error
//   acc    architectural accumulator
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MULDIV_SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sub,
  output logic [2:0] alu_op_select,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic [7:0] acc
);
  localparam logic [7:0] LD_ALU = 8'(settle_eff(SETTLE_CYCLES));
  localparam logic [7:0] LD_MD  = 8'(settle_eff(MULDIV_SETTLE));
  state_e     r_state;
  op_e        r_op;
  logic [7:0] r_data, r_acc, r_rsp_data;
  logic       r_rsp_zero, r_rsp_err;
  op_e        w_op;
  logic       w_idle, w_exec, w_bad, w_direct, w_done;
  assign w_op     = op_e'(cmd_op);
  assign w_idle   = r_state == ST_IDLE;
  assign w_exec   = r_state == ST_EXEC;
  // divide-by-zero and the reserved op never reach the ALU
  assign w_bad    = w_op == OP_RSV || (w_op == OP_DIV && cmd_data == 8'd0);
  assign w_direct = w_op == OP_LDA || w_bad;
  alu_settle_timer #(.W(8)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_idle && cmd_valid && !w_direct),
    .i_load_val(w_op inside {OP_MUL, OP_DIV} ? LD_MD : LD_ALU),
    .i_dec     (w_exec),
    .o_done    (w_done)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ADD;
      r_data     <= '0;
      r_acc      <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else
      case (r_state)
        ST_IDLE:
          if (cmd_valid) begin
            r_op <= w_op;
            if (w_op == OP_LDA) begin
              r_acc      <= cmd_data;
              r_rsp_data <= cmd_data;
              r_rsp_zero <= cmd_data == 8'd0;
              r_rsp_err  <= 1'b0;
              r_state    <= ST_RESP;
            end else if (w_bad) begin
              r_rsp_data <= r_acc;
              r_rsp_zero <= r_acc == 8'd0;
              r_rsp_err  <= 1'b1;
              r_state    <= ST_RESP;
            end else begin
              r_data  <= cmd_data;
              r_state <= ST_EXEC;
            end
          end
        ST_EXEC:
          if (w_done) begin
            r_acc      <= alu_result;
            r_rsp_data <= alu_result;
            r_rsp_zero <= alu_result == 8'd0;
            r_rsp_err  <= 1'b0;
            r_state    <= ST_RESP;
          end
        ST_RESP:
          if (rsp_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
  assign cmd_ready     = w_idle;
  assign rsp_valid     = r_state == ST_RESP;
  assign rsp_data      = r_rsp_data;
  assign rsp_zero      = r_rsp_zero;
  assign rsp_err       = r_rsp_err;
  assign acc           = r_acc;
  assign alu_a         = w_exec ? r_acc : 8'd0;
  assign alu_b         = w_exec ? r_data : 8'd0;
  assign alu_sub       = w_exec && r_op == OP_SUB;
  assign alu_op_select = w_exec ? r_op : 3'd0;
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles ALU operands are held before result capture for ADD/SUB/AND/OR.
REQ-002 Parameter MULDIV_SETTLE, default 4: hold cycles for MUL/DIV, which have deeper gate paths.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high at clk edge
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 LDA, 111 reserved
- cmd_data  in  8  B operand, or load value for LDA
- alu_a  out  8  to ALU a (accumulator copy)
- alu_b  out  8  to ALU b (data register)
- alu_sub  out  1  to ALU sub
- alu_op_select  out  3  to ALU op_select
- alu_result  in  8  from ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_data  out  8  new accumulator value
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  divide-by-zero or reserved opcode
- acc  out  8  architectural accumulator

Function
REQ-004 FSM states IDLE, EXEC, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-005 On accept of ADD/SUB/AND/OR/MUL with a nonzero-divisor-irrelevant case, latch cmd_data into data register, load counter with the applicable settle count, go to EXEC.
REQ-006 In EXEC, alu_a=acc, alu_b=data register, alu_op_select=latched op, alu_sub=1 only for SUB; all four stable for the whole EXEC dwell.
REQ-007 Counter decrements once per EXEC cycle; EXEC lasts exactly the settle count (minimum 1 if parameter is 0); on the last EXEC cycle alu_result is captured into acc and rsp_data, FSM goes to RESP.
REQ-008 rsp_valid SHALL be 1 exactly in RESP; rsp_data/rsp_zero/rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-009 RESP with rsp_ready=1 -> IDLE next cycle; a new command is accepted no earlier than the cycle after.
REQ-010 Latency: accept at edge N -> rsp_valid high from edge N+S+1, S = settle count.
REQ-011 LDA: acc <= cmd_data, skip EXEC, rsp_valid from edge N+1, rsp_err=0.
REQ-012 DIV with cmd_data=0x00: skip EXEC, acc unchanged, rsp_data=acc, rsp_err=1, ALU not driven (alu outputs held at 0).
REQ-013 Reserved op 111: same as REQ-012 (rsp_err=1, acc unchanged).
REQ-014 Arithmetic is 8-bit modulo; no carry/overflow output; rsp_zero derived from captured rsp_data.
REQ-015 Outside EXEC, alu_a, alu_b, alu_sub, alu_op_select SHALL be 0.
REQ-016 cmd_valid while not in IDLE is ignored; no queuing.

Reset
REQ-017 rst_n low SHALL asynchronously force state IDLE, acc, data register, counter, rsp_data, rsp_zero, rsp_err, rsp_valid, all alu_* outputs to 0; cmd_ready=1 after release.
REQ-018 Reset asserted mid-EXEC or mid-RESP SHALL abandon the command with no response and no acc update.

Structure
REQ-019 Shared package alu_pkg SHALL hold the opcode encodings and the FSM state encoding; the ALU and this block use the same opcode constants.
REQ-020 One sub-module, alu_settle_timer (loadable down-counter with done flag), is natural; the remainder is a single module.

Verification
REQ-021 LDA 0x05, then ADD 0x03 -> rsp_data 0x08, rsp_zero 0, rsp_valid exactly 3 edges after accept (SETTLE_CYCLES=2).
REQ-022 LDA 0xFF, ADD 0x01 -> rsp_data 0x00, rsp_zero 1; then SUB 0x01 -> 0xFF with alu_sub=1 throughout EXEC.
REQ-023 LDA 0x0C, MUL 0x03 -> 0x24 after 5 edges; then DIV 0x00 -> rsp_err 1, rsp_data 0x24, acc 0x24, no EXEC cycle.
REQ-024 rsp_ready held low 4 cycles -> rsp_data stable, cmd_ready 0, extra cmd_valid ignored; acceptance resumes one cycle after handshake.
REQ-025 rst_n pulsed low during EXEC of ADD -> all outputs 0 immediately, no rsp_valid, acc 0; op 111 afterwards -> rsp_err 1.
